axi_read_responder: RTL and testbench
=====================================

AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AR/R transaction ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, R data and memory word width, power of two >= 8.
REQ-004 SHALL have parameter USER_WIDTH, default 6, user sideband width.
REQ-005 SHALL have one clock and a synchronous, active-high reset:
- clk_i  in  1  clock, all logic on the rising edge.
- rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have these AR slave ports:
- slave_valid_i  in  1  AR valid.
- slave_addr_i  in  ADDR_WIDTH  start address.
- slave_len_i  in  8  beats minus one.
- slave_size_i  in  3  log2 bytes per beat.
- slave_burst_i  in  2  burst type.
- slave_id_i  in  ID_WIDTH  transaction ID.
- slave_user_i  in  USER_WIDTH  user sideband.
- slave_ready_o  out  1  AR ready.
REQ-007 SHALL have these R master ports:
- master_valid_o  out  1  R valid.
- master_data_o  out  DATA_WIDTH  read data.
- master_resp_o  out  2  response.
- master_last_o  out  1  last beat.
- master_id_o  out  ID_WIDTH  echoed ID.
- master_user_o  out  USER_WIDTH  echoed user.
- master_ready_i  in  1  R ready.
REQ-008 SHALL have these memory ports:
- mem_req_o  out  1  read request.
- mem_addr_o  out  ADDR_WIDTH  word-aligned address (low log2(DATA_WIDTH/8) bits zero).
- mem_rdata_i  in  DATA_WIDTH  data, valid exactly one cycle after mem_req_o.

Function
REQ-009 SHALL implement FSM IDLE/BURST:
- slave_ready_o=1 only in IDLE.
- AR handshake in IDLE latches addr/len/size/burst/id/user, loads beat counter=len, goes to BURST.
REQ-010 SHALL in BURST issue one mem_req_o per beat only when buffered+in-flight beats < 2 (credit rule); throughput is one beat/cycle with master_ready_i held high.
REQ-011 SHALL compute next beat address:
- FIXED(00): unchanged.
- INCR(01): aligned(addr, size) + (1<<size); first beat uses the unaligned start address.
- WRAP(10): increment within a (len+1)<<size byte boundary-aligned window, wrapping to the window base.
REQ-012 SHALL issue no memory requests for an errored burst (burst=11, or size > log2(DATA_WIDTH/8)); it SHALL still return len+1 beats with master_resp_o=2'b10 (SLVERR) and zero data. Otherwise master_resp_o=2'b00.
REQ-013 SHALL assert master_last_o on exactly the (len+1)-th beat.
REQ-014 SHALL return to IDLE in the cycle after the last beat is issued; in-flight beats still drain from the buffer.
REQ-015 SHALL capture mem_rdata_i plus id/user/resp/last into a 2-entry R FIFO one cycle after each request.
REQ-016 SHALL drive master_valid_o from FIFO not-empty, pop on master_valid_o & master_ready_i, and hold all R outputs stable while valid and not ready.
REQ-017 SHALL allow push and pop in the same cycle when the FIFO is full; FIFO overflow is impossible by REQ-010.
REQ-018 SHALL ignore WRAP with len not in {1,3,7,15}; it is treated as SLVERR.

Reset
REQ-019 SHALL on rst_i set FSM=IDLE, FIFO empty, counters zero, master_valid_o=0, mem_req_o=0, slave_ready_o=0 during reset and 1 the cycle after.
REQ-020 SHALL discard an in-progress burst and in-flight data when reset is applied mid-burst; no beat of it appears after reset.

Structure
REQ-021 SHALL place burst encodings (FIXED/INCR/WRAP), response encodings (OKAY/SLVERR) and the FSM state enum in the shared package axi_resp_pkg.
REQ-022 SHALL implement the R FIFO as sub-module axi_r_fifo (2 entries, synchronous active-high reset).

Verification
REQ-023 SHALL cover INCR: addr=0x100, len=3, size=3 -> mem_addr 0x100,0x108,0x110,0x118; 4 OKAY beats, last on beat 4, id echoed.
REQ-024 SHALL cover WRAP: addr=0x118, len=3, size=3 -> mem_addr 0x118,0x100,0x108,0x110.
REQ-025 SHALL cover FIXED: addr=0x40, len=2 -> three requests to 0x40.
REQ-026 SHALL cover backpressure: master_ready_i low for 5 cycles mid-burst -> at most 2 requests outstanding, outputs stable, no beat lost or duplicated.
REQ-027 SHALL cover errors: burst=11, len=1 -> 2 SLVERR beats, zero data, mem_req_o never asserted.
REQ-028 SHALL cover reset mid-burst after beat 2 of 8 -> master_valid_o=0 the cycle after reset, slave_ready_o=1 after release.

Source files
------------

// File: rtl/axi_resp_pkg.sv
// Shared AXI read-responder encodings: burst types, response codes and FSM states.
package axi_resp_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_read_responder_if.sv
// AR / R / memory signal bundle; "master" is the requester side, "slave" the responder.
interface axi_read_responder_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6
);
    logic                  slave_valid;
    logic                  slave_ready;
    logic [ADDR_WIDTH-1:0] slave_addr;
    logic [7:0]            slave_len;
    logic [2:0]            slave_size;
    logic [1:0]            slave_burst;
    logic [ID_WIDTH-1:0]   slave_id;
    logic [USER_WIDTH-1:0] slave_user;

    logic                  master_valid;
    logic                  master_ready;
    logic [DATA_WIDTH-1:0] master_data;
    logic [1:0]            master_resp;
    logic                  master_last;
    logic [ID_WIDTH-1:0]   master_id;
    logic [USER_WIDTH-1:0] master_user;

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output slave_valid, slave_addr, slave_len, slave_size, slave_burst, slave_id, slave_user,
        input  slave_ready,
        input  master_valid, master_data, master_resp, master_last, master_id, master_user,
        output master_ready,
        input  mem_req, mem_addr,
        output mem_rdata
    );

    modport slave (
        input  slave_valid, slave_addr, slave_len, slave_size, slave_burst, slave_id, slave_user,
        output slave_ready,
        output master_valid, master_data, master_resp, master_last, master_id, master_user,
        input  master_ready,
        output mem_req, mem_addr,
        input  mem_rdata
    );
endinterface

// File: rtl/axi_r_fifo.sv
// Two-entry R-beat FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module axi_r_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);
    logic [1:0][WIDTH-1:0] mem_q;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (cnt_q != 2'd0);
        do_push  = push_i && ((cnt_q != 2'd2) || do_pop);
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (cnt_q != 2'd0);
    assign count_o = cnt_q;

endmodule

// File: rtl/axi_read_responder.sv
// AXI read responder: accepts one AR burst at a time, reads a 1-cycle-latency memory per beat
// and returns R beats through a 2-entry FIFO; illegal bursts answer SLVERR without touching memory.
module axi_read_responder
    import axi_resp_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  slave_valid_i,
    input  logic [ADDR_WIDTH-1:0] slave_addr_i,
    input  logic [7:0]            slave_len_i,
    input  logic [2:0]            slave_size_i,
    input  logic [1:0]            slave_burst_i,
    input  logic [ID_WIDTH-1:0]   slave_id_i,
    input  logic [USER_WIDTH-1:0] slave_user_i,
    output logic                  slave_ready_o,

    output logic                  master_valid_o,
    output logic [DATA_WIDTH-1:0] master_data_o,
    output logic [1:0]            master_resp_o,
    output logic                  master_last_o,
    output logic [ID_WIDTH-1:0]   master_id_o,
    output logic [USER_WIDTH-1:0] master_user_o,
    input  logic                  master_ready_i,

    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    localparam int BYTES_LOG2 = $clog2(DATA_WIDTH / 8);
    localparam int FIFO_W     = ID_WIDTH + USER_WIDTH + 2 + 1 + DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~(ADDR_WIDTH'((1 << BYTES_LOG2) - 1));

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beats_q, beats_d;
    logic [2:0]            size_q, size_d;
    burst_e                burst_q, burst_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic                  err_q, err_d;

    // Beat issued last cycle; its memory data arrives this cycle and is pushed with this sideband.
    logic                  infl_q, infl_d;
    logic                  infl_last_q, infl_last_d;
    logic                  infl_err_q, infl_err_d;
    logic [ID_WIDTH-1:0]   infl_id_q, infl_id_d;
    logic [USER_WIDTH-1:0] infl_user_q, infl_user_d;

    logic                  ar_hs, ar_err, issue, credit_ok, pop;
    logic [2:0]            occ;
    logic [1:0]            fifo_cnt;
    logic                  fifo_valid;
    logic [FIFO_W-1:0]     fifo_din, fifo_dout;
    logic [ADDR_WIDTH-1:0] step, aligned, incr_addr, wrap_mask, next_addr;

    assign ar_hs  = slave_valid_i && slave_ready_o;
    assign ar_err = (burst_e'(slave_burst_i) == BURST_RSVD)
                 || (int'(slave_size_i) > BYTES_LOG2)
                 || ((burst_e'(slave_burst_i) == BURST_WRAP) && !wrap_len_ok(slave_len_i));

    // Occupancy once this cycle's pop and in-flight push settle; a new beat needs a free slot there.
    assign pop       = master_valid_o && master_ready_i;
    assign occ       = {1'b0, fifo_cnt} + {2'b0, infl_q} - {2'b0, pop};
    assign credit_ok = (occ < 3'd2);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ar_hs) state_d = ST_BURST;
            ST_BURST: if (issue && (beats_q == 8'd0)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        slave_ready_o = 1'b0;
        issue         = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ST_IDLE:  slave_ready_o = 1'b1;
                ST_BURST: issue = credit_ok;
                default:  ;
            endcase
        end
    end

    always_comb begin
        step      = ADDR_WIDTH'(1) << size_q;
        aligned   = addr_q & ~(step - ADDR_WIDTH'(1));
        incr_addr = aligned + step;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        case (burst_q)
            BURST_INCR: next_addr = incr_addr;
            BURST_WRAP: next_addr = (aligned & ~wrap_mask) | (incr_addr & wrap_mask);
            default:    next_addr = addr_q;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        len_d       = len_q;
        beats_d     = beats_q;
        size_d      = size_q;
        burst_d     = burst_q;
        id_d        = id_q;
        user_d      = user_q;
        err_d       = err_q;
        infl_d      = issue;
        infl_last_d = (beats_q == 8'd0);
        infl_err_d  = err_q;
        infl_id_d   = id_q;
        infl_user_d = user_q;
        if (ar_hs) begin
            addr_d  = slave_addr_i;
            len_d   = slave_len_i;
            beats_d = slave_len_i;
            size_d  = slave_size_i;
            burst_d = burst_e'(slave_burst_i);
            id_d    = slave_id_i;
            user_d  = slave_user_i;
            err_d   = ar_err;
        end else if (issue) begin
            addr_d  = next_addr;
            beats_d = beats_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            len_q       <= '0;
            beats_q     <= '0;
            size_q      <= '0;
            burst_q     <= BURST_FIXED;
            id_q        <= '0;
            user_q      <= '0;
            err_q       <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            infl_err_q  <= 1'b0;
            infl_id_q   <= '0;
            infl_user_q <= '0;
        end else begin
            addr_q      <= addr_d;
            len_q       <= len_d;
            beats_q     <= beats_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            id_q        <= id_d;
            user_q      <= user_d;
            err_q       <= err_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            infl_err_q  <= infl_err_d;
            infl_id_q   <= infl_id_d;
            infl_user_q <= infl_user_d;
        end
    end

    assign mem_req_o  = issue && !err_q;
    assign mem_addr_o = addr_q & WORD_MASK;

    assign fifo_din = {infl_id_q, infl_user_q,
                       (infl_err_q ? RESP_SLVERR : RESP_OKAY),
                       infl_last_q,
                       (infl_err_q ? {DATA_WIDTH{1'b0}} : mem_rdata_i)};

    axi_r_fifo #(.WIDTH(FIFO_W)) u_r_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (infl_q),
        .data_i  (fifo_din),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .valid_o (fifo_valid),
        .count_o (fifo_cnt)
    );

    assign master_valid_o = fifo_valid && !rst_i;
    assign {master_id_o, master_user_o, master_resp_o, master_last_o, master_data_o} = fifo_dout;

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: INCR/WRAP/FIXED bursts, backpressure, error bursts, mid-burst reset.
module tb_axi_read_responder;
    import axi_resp_pkg::*;

    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int UW  = 6;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [UW-1:0]  user;
        logic [1:0]     resp;
        logic           last;
        logic [DW-1:0]  data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_read_responder_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) bus ();

    axi_read_responder #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .slave_valid_i  (bus.slave_valid),
        .slave_addr_i   (bus.slave_addr),
        .slave_len_i    (bus.slave_len),
        .slave_size_i   (bus.slave_size),
        .slave_burst_i  (bus.slave_burst),
        .slave_id_i     (bus.slave_id),
        .slave_user_i   (bus.slave_user),
        .slave_ready_o  (bus.slave_ready),
        .master_valid_o (bus.master_valid),
        .master_data_o  (bus.master_data),
        .master_resp_o  (bus.master_resp),
        .master_last_o  (bus.master_last),
        .master_id_o    (bus.master_id),
        .master_user_o  (bus.master_user),
        .master_ready_i (bus.master_ready),
        .mem_req_o      (bus.mem_req),
        .mem_addr_o     (bus.mem_addr),
        .mem_rdata_i    (bus.mem_rdata)
    );

    // Memory returns {~addr, addr} one cycle after a request.
    always @(posedge clk)
        bus.mem_rdata <= bus.mem_req ? {~bus.mem_addr, bus.mem_addr} : 64'hBAD0_BAD0_BAD0_BAD0;

    logic [AW-1:0] req_q[$];
    beat_t         beat_q[$];
    int            n_req = 0;
    int            n_pop = 0;
    int            tests = 0;
    int            fails = 0;
    logic [AW-1:0] ea [8];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_req) begin
                req_q.push_back(bus.mem_addr);
                n_req++;
            end
            if (bus.master_valid && bus.master_ready) begin
                beat_t b;
                b.id = bus.master_id; b.user = bus.master_user; b.resp = bus.master_resp;
                b.last = bus.master_last; b.data = bus.master_data;
                beat_q.push_back(b);
                n_pop++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input logic [5:0] user);
        int k = 0;
        @(posedge clk); #1;
        bus.slave_addr = a; bus.slave_len = len; bus.slave_size = size;
        bus.slave_burst = burst; bus.slave_id = id; bus.slave_user = user;
        bus.slave_valid = 1'b1;
        @(negedge clk);
        while (!bus.slave_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("ar handshake ready", 64'(bus.slave_ready), 64'd1);
        @(posedge clk); #1;
        bus.slave_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (beat_q.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_burst(input string tag, input int n, input logic [1:0] resp,
                               input logic [3:0] id, input logic [5:0] user, input bit err);
        beat_t         b;
        logic [AW-1:0] a;
        wait_beats(n);
        chk({tag, " beat count"}, 64'(beat_q.size()), 64'(n));
        chk({tag, " req count"}, 64'(req_q.size()), err ? 64'd0 : 64'(n));
        for (int i = 0; i < n && beat_q.size() > 0; i++) begin
            b = beat_q.pop_front();
            if (!err && req_q.size() > 0) begin
                a = req_q.pop_front();
                chk($sformatf("%s addr%0d", tag, i), 64'(a), 64'(ea[i]));
            end
            chk($sformatf("%s data%0d", tag, i), b.data, err ? 64'd0 : {~ea[i], ea[i]});
            chk($sformatf("%s last%0d", tag, i), 64'(b.last), 64'(i == n - 1));
            chk($sformatf("%s resp%0d", tag, i), 64'(b.resp), 64'(resp));
            chk($sformatf("%s id%0d", tag, i), 64'(b.id), 64'(id));
            chk($sformatf("%s user%0d", tag, i), 64'(b.user), 64'(user));
        end
        beat_q.delete();
        req_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] snap_data;
        logic [12:0]   snap_meta;
        int            k;
        bus.slave_valid = 1'b0; bus.slave_addr = '0; bus.slave_len = '0; bus.slave_size = '0;
        bus.slave_burst = '0; bus.slave_id = '0; bus.slave_user = '0; bus.master_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset slave_ready", 64'(bus.slave_ready), 64'd0);
        chk("reset master_valid", 64'(bus.master_valid), 64'd0);
        chk("reset mem_req", 64'(bus.mem_req), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready after reset", 64'(bus.slave_ready), 64'd1);

        send_ar(32'h100, 8'd3, 3'd3, 2'b01, 4'h5, 6'h2A);
        ea = '{32'h100, 32'h108, 32'h110, 32'h118, 0, 0, 0, 0};
        check_burst("incr", 4, 2'b00, 4'h5, 6'h2A, 1'b0);

        send_ar(32'h118, 8'd3, 3'd3, 2'b10, 4'hA, 6'h01);
        ea = '{32'h118, 32'h100, 32'h108, 32'h110, 0, 0, 0, 0};
        check_burst("wrap", 4, 2'b00, 4'hA, 6'h01, 1'b0);

        send_ar(32'h40, 8'd2, 3'd3, 2'b00, 4'h7, 6'h3F);
        ea = '{32'h40, 32'h40, 32'h40, 0, 0, 0, 0, 0};
        check_burst("fixed", 3, 2'b00, 4'h7, 6'h3F, 1'b0);

        // Unaligned narrow INCR: beats at 0x104, 0x108, 0x10C map onto words 0x100, 0x108, 0x108.
        send_ar(32'h104, 8'd2, 3'd2, 2'b01, 4'h1, 6'h05);
        ea = '{32'h100, 32'h108, 32'h108, 0, 0, 0, 0, 0};
        check_burst("narrow", 3, 2'b00, 4'h1, 6'h05, 1'b0);

        send_ar(32'h80, 8'd1, 3'd3, 2'b11, 4'hC, 6'h12);
        check_burst("err burst11", 2, 2'b10, 4'hC, 6'h12, 1'b1);
        send_ar(32'h80, 8'd0, 3'd4, 2'b01, 4'h2, 6'h13);
        check_burst("err size", 1, 2'b10, 4'h2, 6'h13, 1'b1);
        send_ar(32'h80, 8'd2, 3'd3, 2'b10, 4'h3, 6'h14);
        check_burst("err wraplen", 3, 2'b10, 4'h3, 6'h14, 1'b1);

        send_ar(32'h200, 8'd7, 3'd3, 2'b01, 4'h3, 6'h11);
        k = 0;
        while (beat_q.size() < 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1 bus.master_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp valid%0d", i), 64'(bus.master_valid), 64'd1);
            chk($sformatf("bp outstanding%0d", i), 64'((n_req - n_pop) <= 2), 64'd1);
            if (i == 0) begin
                snap_data = bus.master_data;
                snap_meta = {bus.master_id, bus.master_user, bus.master_resp, bus.master_last};
            end else begin
                chk($sformatf("bp data stable%0d", i), bus.master_data, snap_data);
                chk($sformatf("bp meta stable%0d", i),
                    64'({bus.master_id, bus.master_user, bus.master_resp, bus.master_last}), 64'(snap_meta));
            end
        end
        @(posedge clk); #1 bus.master_ready = 1'b1;
        ea = '{32'h200, 32'h208, 32'h210, 32'h218, 32'h220, 32'h228, 32'h230, 32'h238};
        check_burst("bp", 8, 2'b00, 4'h3, 6'h11, 1'b0);

        send_ar(32'h300, 8'd7, 3'd3, 2'b01, 4'h9, 6'h01);
        k = 0;
        while (beat_q.size() < 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("midrst beats before reset", 64'(beat_q.size() >= 2), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        beat_q.delete();
        req_q.delete();
        @(negedge clk);
        chk("midrst valid in reset", 64'(bus.master_valid), 64'd0);
        chk("midrst mem_req in reset", 64'(bus.mem_req), 64'd0);
        chk("midrst ready in reset", 64'(bus.slave_ready), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst valid after reset", 64'(bus.master_valid), 64'd0);
        chk("midrst ready after reset", 64'(bus.slave_ready), 64'd1);
        repeat (20) @(negedge clk);
        chk("midrst stale beats", 64'(beat_q.size()), 64'd0);
        chk("midrst stale reqs", 64'(req_q.size()), 64'd0);

        send_ar(32'h8, 8'd0, 3'd3, 2'b01, 4'h2, 6'h20);
        ea = '{32'h8, 0, 0, 0, 0, 0, 0, 0};
        check_burst("single", 1, 2'b00, 4'h2, 6'h20, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
